// File: rtl/phys_tag_pkg.sv
// ----------------------------------------------------------------------------
// phys_tag_pkg : shared sizes and types for the physical tag free list
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package phys_tag_pkg;

  localparam int TAG_W    = 6;
  localparam int NUM_TAGS = 64;
  localparam int NUM_ARCH = 32;
  localparam int FL_DEPTH = NUM_TAGS - NUM_ARCH;
  localparam int PTR_W    = $clog2(FL_DEPTH) + 1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] fl_ptr_t;

endpackage

`default_nettype wire

// File: rtl/fl_wrap_ptr.sv
// ----------------------------------------------------------------------------
// fl_wrap_ptr : wrap-bit pointer register with increment and parallel load
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fl_wrap_ptr
  import phys_tag_pkg::*;
#(
  parameter logic [PTR_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             load,
  input  logic [PTR_W-1:0] loadVal,
  output logic [PTR_W-1:0] ptr
);

  // Load wins over increment; the MSB toggles on wrap and tells full from empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= RST_VAL;
    end else if (load) begin
      ptr <= loadVal;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/phys_tag_free_list.sv
// ----------------------------------------------------------------------------
// phys_tag_free_list : circular free list of physical tags with flush rewind.
// Optional checker bitmap and assertions under macro FREE_LIST_CHECK_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module phys_tag_free_list
  import phys_tag_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             softReset,
  input  logic             allocReq,
  output logic [TAG_W-1:0] allocTag,
  output logic             allocValid,
  input  logic             freeReq,
  input  logic [TAG_W-1:0] freeTag,
  input  logic             commitAlloc,
  output logic [PTR_W-1:0] freeCount
);

  localparam int IDX_W = PTR_W - 1;

  tag_t    mem [FL_DEPTH];
  fl_ptr_t spec_head;
  fl_ptr_t commit_head;
  fl_ptr_t tail;
  fl_ptr_t commit_next;
  fl_ptr_t occupancy;
  logic    alloc_fire;
  logic    free_fire;
  logic    commit_fire;

  assign allocTag    = mem[spec_head[IDX_W-1:0]];
  assign freeCount   = tail - spec_head;
  assign allocValid  = (freeCount != '0);

  // Overflow is judged against the committed head: speculatively allocated
  // slots are still physically occupied until they retire.
  assign occupancy   = tail - commit_head;
  assign alloc_fire  = allocReq && allocValid && !softReset;
  assign free_fire   = freeReq && (occupancy != fl_ptr_t'(FL_DEPTH));
  assign commit_fire = commitAlloc && (commit_head != spec_head);
  assign commit_next = commit_head + fl_ptr_t'(commit_fire);

  fl_wrap_ptr #(.RST_VAL('0)) u_spec_head (
    .clk     (clk),
    .reset   (reset),
    .inc     (alloc_fire),
    .load    (softReset),
    .loadVal (commit_next),
    .ptr     (spec_head)
  );

  fl_wrap_ptr #(.RST_VAL('0)) u_commit_head (
    .clk     (clk),
    .reset   (reset),
    .inc     (commit_fire),
    .load    (1'b0),
    .loadVal ('0),
    .ptr     (commit_head)
  );

  fl_wrap_ptr #(.RST_VAL(fl_ptr_t'(FL_DEPTH))) u_tail (
    .clk     (clk),
    .reset   (reset),
    .inc     (free_fire),
    .load    (1'b0),
    .loadVal ('0),
    .ptr     (tail)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= tag_t'(NUM_ARCH + i);
      end
    end else if (free_fire) begin
      mem[tail[IDX_W-1:0]] <= freeTag;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic [NUM_TAGS-1:0] in_list;
  logic [NUM_TAGS-1:0] in_list_next;
  fl_ptr_t             rewind_len;

  assign rewind_len = spec_head - commit_next;

  // A flush puts back every tag between the new committed head and the old
  // speculative head.
  always_comb begin
    in_list_next = in_list;
    if (alloc_fire) begin
      in_list_next[allocTag] = 1'b0;
    end
    if (softReset) begin
      for (int k = 0; k < FL_DEPTH; k++) begin
        if ({1'b0, IDX_W'(k) - commit_next[IDX_W-1:0]} < rewind_len) begin
          in_list_next[mem[k]] = 1'b1;
        end
      end
    end
    if (free_fire) begin
      in_list_next[freeTag] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        in_list[i] <= (i >= NUM_ARCH);
      end
    end else begin
      in_list <= in_list_next;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      if (freeReq && in_list[freeTag]) $error("free list: duplicate free of tag %0d", freeTag);
      if (freeReq && !free_fire) $error("free list: free of tag %0d into a full list", freeTag);
      if (commitAlloc && !commit_fire) $error("free list: commitAlloc with nothing allocated");
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_phys_tag_free_list.sv
// ----------------------------------------------------------------------------
// tb_phys_tag_free_list : directed bench with a queue-based reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_phys_tag_free_list;
  import phys_tag_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             softReset = 1'b0;
  logic             allocReq = 1'b0;
  logic [TAG_W-1:0] allocTag;
  logic             allocValid;
  logic             freeReq = 1'b0;
  logic [TAG_W-1:0] freeTag = '0;
  logic             commitAlloc = 1'b0;
  logic [PTR_W-1:0] freeCount;

  int total = 0;
  int bad   = 0;

  phys_tag_free_list dut (
    .clk         (clk),
    .reset       (reset),
    .softReset   (softReset),
    .allocReq    (allocReq),
    .allocTag    (allocTag),
    .allocValid  (allocValid),
    .freeReq     (freeReq),
    .freeTag     (freeTag),
    .commitAlloc (commitAlloc),
    .freeCount   (freeCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: q holds every physically present tag from committed head to tail;
  // the first spec_off entries have been handed out speculatively.
  int q[$];
  int spec_off = 0;
  bit model_ok = 0;

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      for (int i = 0; i < FL_DEPTH; i++) q.push_back(NUM_ARCH + i);
      spec_off = 0;
      model_ok = 1;
    end else if (model_ok) begin
      bit a, c, f;
      a = allocReq && (spec_off < q.size()) && !softReset;
      c = commitAlloc && (spec_off > 0);
      f = freeReq && (q.size() < FL_DEPTH);
      if (c) begin
        void'(q.pop_front());
        spec_off--;
      end
      if (a) spec_off++;
      if (softReset) spec_off = 0;
      if (f) q.push_back(int'(freeTag));
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("allocValid", 32'(allocValid), 32'(spec_off < q.size()));
      chk("freeCount", 32'(freeCount), 32'(q.size() - spec_off));
      if (spec_off < q.size()) chk("allocTag", 32'(allocTag), 32'(q[spec_off]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    step(1);
    reset = 1'b1;
    chk("rst_valid", 32'(allocValid), 32'd1);
    chk("rst_tag", 32'(allocTag), 32'd32);
    chk("rst_count", 32'(freeCount), 32'd32);

    // drain, then one extra request while empty
    allocReq = 1'b1;
    step(32);
    chk("drain_valid", 32'(allocValid), 32'd0);
    chk("drain_count", 32'(freeCount), 32'd0);
    step(1);
    allocReq = 1'b0;
    chk("empty_req_count", 32'(freeCount), 32'd0);

    // retire everything, plus one illegal commit
    commitAlloc = 1'b1;
    step(33);
    commitAlloc = 1'b0;

    // free into empty with concurrent alloc: no bypass
    freeReq = 1'b1; freeTag = 6'd5; allocReq = 1'b1;
    step(1);
    freeReq = 1'b0; allocReq = 1'b0;
    chk("f2a_valid", 32'(allocValid), 32'd1);
    chk("f2a_tag", 32'(allocTag), 32'd5);
    chk("f2a_count", 32'(freeCount), 32'd1);
    step(1);

    // alloc 4, commit 2, flush
    reset = 1'b0; step(1); reset = 1'b1;
    allocReq = 1'b1; step(4); allocReq = 1'b0;
    commitAlloc = 1'b1; step(2); commitAlloc = 1'b0;
    softReset = 1'b1; step(1); softReset = 1'b0;
    chk("flush_tag", 32'(allocTag), 32'd34);
    chk("flush_count", 32'(freeCount), 32'd30);

    // steady alloc+free+commit keeps the count constant
    allocReq = 1'b1; step(20);
    chk("cnt10", 32'(freeCount), 32'd10);
    commitAlloc = 1'b1; freeReq = 1'b1; freeTag = 6'd7;
    step(5);
    commitAlloc = 1'b0; freeReq = 1'b0;
    chk("steady_count", 32'(freeCount), 32'd10);
    step(5);
    chk("fifo_tag7", 32'(allocTag), 32'd7);
    step(5);
    allocReq = 1'b0;
    chk("fifo_empty", 32'(freeCount), 32'd0);

    // reset mid-stream discards a concurrent free
    reset = 1'b0; step(1); reset = 1'b1;
    allocReq = 1'b1; step(3);
    reset = 1'b0; freeReq = 1'b1; freeTag = 6'd9;
    step(1);
    reset = 1'b1; freeReq = 1'b0; allocReq = 1'b0;
    chk("midrst_valid", 32'(allocValid), 32'd1);
    chk("midrst_tag", 32'(allocTag), 32'd32);
    chk("midrst_count", 32'(freeCount), 32'd32);

    // flush with same-cycle commit; free into a physically full list is dropped
    allocReq = 1'b1; step(5);
    commitAlloc = 1'b1; softReset = 1'b1; freeReq = 1'b1; freeTag = 6'd3;
    step(1);
    commitAlloc = 1'b0; softReset = 1'b0; freeReq = 1'b0; allocReq = 1'b0;
    chk("flushc_tag", 32'(allocTag), 32'd33);
    chk("flushc_count", 32'(freeCount), 32'd31);
    freeReq = 1'b1; freeTag = 6'd3;
    step(1);
    freeReq = 1'b0;
    chk("refill_count", 32'(freeCount), 32'd32);
    allocReq = 1'b1; step(31);
    chk("wrap_tag3", 32'(allocTag), 32'd3);
    step(1);
    allocReq = 1'b0;
    chk("wrap_empty", 32'(allocValid), 32'd0);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/phys_tag_free_list.md
Name: phys_tag_free_list

Overview:
- Circular free list of physical register tags for the rename stage.
- Each cycle it offers the next free tag (first-word-fall-through) to the rename pipeline register, which sits directly downstream and is a 6-bit enable-DFF wall.
- Tags return from commit.
- A committed read pointer lets a pipeline flush (softReset) reclaim every tag allocated speculatively since the last commit.

Parameters:
- TAG_W, 6: physical tag width.
- NUM_TAGS, 64: total physical registers.
- NUM_ARCH, 32: architectural registers; tags 0..NUM_ARCH-1 are mapped at reset.
- FL_DEPTH = NUM_TAGS-NUM_ARCH (32), derived: free list capacity.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- softReset  in  1  pipeline flush: rewind speculative head to committed head.
- allocReq  in  1  rename consumes allocTag this cycle.
- allocTag  out  TAG_W  tag at speculative head; meaningful only when allocValid.
- allocValid  out  1  list non-empty (speculative view).
- freeReq  in  1  commit returns a tag.
- freeTag  in  TAG_W  tag being returned.
- commitAlloc  in  1  an allocating instruction retired; advance committed head.
- freeCount  out  $clog2(FL_DEPTH)+1  free tags visible to rename (0..FL_DEPTH).

Behaviour:
- Storage and pointers:
  - Storage: FL_DEPTH x TAG_W entries.
  - Pointers specHead, commitHead and tail are each $clog2(FL_DEPTH)+1 bits, with the MSB as the wrap bit.
- Reset (reset==0 at posedge):
  - mem[i] = NUM_ARCH+i.
  - specHead = commitHead = 0; tail = {1,0...0}, so the list is full.
  - Outputs after reset: allocValid=1, allocTag=NUM_ARCH, freeCount=FL_DEPTH.
  - Reset overrides every other input in the same cycle, including reset asserted mid-operation.
- Outputs (combinational from state):
  - allocTag = mem[specHead].
  - freeCount = tail - specHead.
  - allocValid = (freeCount != 0).
- Allocate: on allocReq && allocValid && !softReset, specHead increments. allocReq while empty is ignored.
- Free:
  - On freeReq, mem[tail] <= freeTag and tail increments.
  - Physical occupancy is tail - commitHead. A free when occupancy==FL_DEPTH is dropped and does not corrupt state.
  - No bypass: a tag freed into an empty list is allocatable the next cycle (1-cycle free-to-alloc latency).
- commitAlloc:
  - commitHead increments when commitHead != specHead.
  - Otherwise it is ignored (illegal commit).
- softReset:
  - specHead <= commitHead_next, which includes any commitAlloc in the same cycle.
  - allocReq in the same cycle is ignored.
  - freeReq in the same cycle is applied.
- Simultaneous alloc+free: both occur and freeCount is unchanged. Wrap-around is handled by the pointer MSB; full vs empty is distinguished by the wrap bit.
- No state machine beyond the pointers. All updates are on the rising edge of clk.

Optional Feature:
- FREE_LIST_CHECK_EN, when defined:
  - Adds a NUM_TAGS-bit inList bitmap: set on free, cleared on alloc, restored on softReset by re-setting the tags in the rewound window.
  - Raises simulation $error on a duplicate free, on an overflow free, and on an illegal commitAlloc.
  - Adds no ports.
- When undefined: no bitmap and no checks; the block is functionally identical.

Decomposition:
- Package phys_tag_pkg: TAG_W, NUM_TAGS, NUM_ARCH, FL_DEPTH, PTR_W, typedef tag_t (logic [TAG_W-1:0]), typedef fl_ptr_t (logic [PTR_W-1:0]).
- Sub-module fl_wrap_ptr: wrap-bit pointer register with inc, load and loadVal, synchronous active-low reset to a parameterised value.
- Instances: specHead (load on softReset), commitHead and tail.

Test Plan:
- Reset low for 1 cycle, then high -> allocValid=1, allocTag=32, freeCount=32.
- allocReq=1 for 33 cycles -> allocTag sequence 32..63; then allocValid=0, freeCount=0; the 33rd request causes no pointer change.
- From empty, freeReq with freeTag=5 together with allocReq -> no alloc that cycle; next cycle allocValid=1, allocTag=5, freeCount=1.
- From reset: allocate 4 (tags 32..35), pulse commitAlloc twice, then softReset -> next cycle allocTag=34, freeCount=30.
- With freeCount=10: allocReq and freeReq (tag 7) for 5 cycles -> freeCount stays 10; tag 7 later emerges in FIFO order.
- Allocate 3, then assert reset low mid-stream with freeReq=1 -> state returns to the reset values; the free is discarded.
- Only with FREE_LIST_CHECK_EN: freeing tag 40 while it is still in the list -> $error is raised.
